// File: rtl/hazard_track_pipe_pkg.sv
// Shared opcode/funct constants, Tnew encodings, the per-stage hazard record and the D-stage decoder.
// Single source of instruction recognition for the hazard-tracking pipeline.
package hazard_track_pipe_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  a3;
    logic        regwr;
    logic [1:0]  tnew;
  } hz_t;

  function automatic hz_t decode(input logic [31:0] instr, input logic [31:0] pc);
    hz_t r;
    r.instr = instr;
    r.pc    = pc;
    r.a3    = 5'd0;
    r.regwr = 1'b0;
    r.tnew  = TNEW_0;
    unique case (instr[31:26])
      OP_RTYPE: begin
        if (instr[5:0] == FUNCT_ADDU || instr[5:0] == FUNCT_SUBU) begin
          r.a3    = instr[15:11];
          r.regwr = 1'b1;
          r.tnew  = TNEW_1;
        end
      end
      OP_ORI, OP_LUI: begin
        r.a3    = instr[20:16];
        r.regwr = 1'b1;
        r.tnew  = TNEW_1;
      end
      OP_LW: begin
        r.a3    = instr[20:16];
        r.regwr = 1'b1;
        r.tnew  = TNEW_2;
      end
      OP_JAL: begin
        r.a3    = REG_RA;
        r.regwr = 1'b1;
        r.tnew  = TNEW_0;
      end
      default: ;
    endcase
    // $0 is hard-wired, so a write to it is never a hazard source.
    if (r.a3 == 5'd0) r.regwr = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/hazard_track_pipe_stage.sv
// One pipeline register for the hazard record, 1-cycle latency; bubble (or reset) loads an empty slot.
// Optional saturating Tnew decrement on load; no backpressure of its own.
module hazard_stage_reg
  import hazard_track_pipe_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter bit          DEC_TNEW = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic bubble,
  input  hz_t  d,
  output hz_t  q
);

  localparam hz_t EMPTY = '{instr: 32'd0, pc: PC_RESET, a3: 5'd0, regwr: 1'b0, tnew: TNEW_0};

  hz_t nxt;

  always_comb begin
    nxt = d;
    if (DEC_TNEW && d.tnew != TNEW_0) nxt.tnew = d.tnew - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset || bubble) q <= EMPTY;
    else                 q <= nxt;
  end

endmodule

// File: rtl/hazard_track_pipe.sv
// D->E, E->M, M->W hazard-field registers feeding the stall unit; 1 cycle per stage.
// stall/flush_E bubble only E; M and W always advance so older producers drain.
module hazard_track_pipe
  import hazard_track_pipe_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_E,
  input  logic [31:0] instr_D,
  input  logic [31:0] pc_D,
  output logic [31:0] instr_E,
  output logic [31:0] instr_M,
  output logic [31:0] instr_W,
  output logic [31:0] pc_E,
  output logic [31:0] pc_M,
  output logic [31:0] pc_W,
  output logic [4:0]  A3_E,
  output logic [4:0]  A3_M,
  output logic [4:0]  A3_W,
  output logic        RegWr_E,
  output logic        RegWr_M,
  output logic        RegWr_W,
  output logic [1:0]  Tnew_E,
  output logic [1:0]  Tnew_M,
  output logic [1:0]  Tnew_W
);

  hz_t dec_d, st_e, st_m, st_w;

  assign dec_d = decode(instr_D, pc_D);

  hazard_stage_reg #(.PC_RESET(PC_RESET), .DEC_TNEW(1'b0)) u_reg_e (
    .clk(clk), .reset(reset), .bubble(stall | flush_E), .d(dec_d), .q(st_e)
  );

  hazard_stage_reg #(.PC_RESET(PC_RESET), .DEC_TNEW(1'b1)) u_reg_m (
    .clk(clk), .reset(reset), .bubble(1'b0), .d(st_e), .q(st_m)
  );

  hazard_stage_reg #(.PC_RESET(PC_RESET), .DEC_TNEW(1'b1)) u_reg_w (
    .clk(clk), .reset(reset), .bubble(1'b0), .d(st_m), .q(st_w)
  );

  assign instr_E = st_e.instr;
  assign instr_M = st_m.instr;
  assign instr_W = st_w.instr;
  assign pc_E    = st_e.pc;
  assign pc_M    = st_m.pc;
  assign pc_W    = st_w.pc;
  assign A3_E    = st_e.a3;
  assign A3_M    = st_m.a3;
  assign A3_W    = st_w.a3;
  assign RegWr_E = st_e.regwr;
  assign RegWr_M = st_m.regwr;
  assign RegWr_W = st_w.regwr;
  assign Tnew_E  = st_e.tnew;
  assign Tnew_M  = st_m.tnew;
  assign Tnew_W  = st_w.tnew;

endmodule

// File: tb/tb_hazard_track_pipe.sv
// Directed bench for hazard_track_pipe: expected E records queued at drive time, popped after each edge.
module tb_hazard_track_pipe;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  a3;
    logic        wr;
    logic [1:0]  tn;
  } rec_t;

  localparam logic [31:0] PCR     = 32'h0000_3000;
  localparam logic [31:0] I_LW8   = 32'h8C08_0000;
  localparam logic [31:0] I_NOP   = 32'h0000_0000;
  localparam logic [31:0] I_ADDU  = 32'h0022_1821;
  localparam logic [31:0] I_JAL   = 32'h0C00_0C10;
  localparam logic [31:0] I_ORI0  = 32'h3420_0005;
  localparam logic [31:0] I_SW    = 32'hAC01_0004;
  localparam logic [31:0] I_JUNK  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset, stall, flush_E;
  logic [31:0] instr_D, pc_D;
  logic [31:0] instr_E, instr_M, instr_W, pc_E, pc_M, pc_W;
  logic [4:0]  A3_E, A3_M, A3_W;
  logic        RegWr_E, RegWr_M, RegWr_W;
  logic [1:0]  Tnew_E, Tnew_M, Tnew_W;

  int   passed = 0;
  int   total  = 0;
  rec_t exp_q[$];
  rec_t m_e, m_m, m_w;

  always #5 clk = ~clk;

  hazard_track_pipe #(.PC_RESET(PCR)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush_E(flush_E),
    .instr_D(instr_D), .pc_D(pc_D),
    .instr_E(instr_E), .instr_M(instr_M), .instr_W(instr_W),
    .pc_E(pc_E), .pc_M(pc_M), .pc_W(pc_W),
    .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
    .RegWr_E(RegWr_E), .RegWr_M(RegWr_M), .RegWr_W(RegWr_W),
    .Tnew_E(Tnew_E), .Tnew_M(Tnew_M), .Tnew_W(Tnew_W)
  );

  function automatic rec_t empty_rec();
    return '{instr: 32'd0, pc: PCR, a3: 5'd0, wr: 1'b0, tn: 2'd0};
  endfunction

  // Reference decode written from the instruction table.
  function automatic rec_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    rec_t r;
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    r = '{instr: ins, pc: pc, a3: 5'd0, wr: 1'b0, tn: 2'd0};
    if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) r = '{ins, pc, ins[15:11], 1'b1, 2'd1};
    else if (op == 6'h0D || op == 6'h0F)              r = '{ins, pc, ins[20:16], 1'b1, 2'd1};
    else if (op == 6'h23)                             r = '{ins, pc, ins[20:16], 1'b1, 2'd2};
    else if (op == 6'h03)                             r = '{ins, pc, 5'd31, 1'b1, 2'd0};
    if (r.a3 == 5'd0) r.wr = 1'b0;
    return r;
  endfunction

  function automatic rec_t age(input rec_t r);
    rec_t o;
    o = r;
    if (o.tn != 2'd0) o.tn = o.tn - 2'd1;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_stage(input string s, input rec_t e,
                             input logic [31:0] ins, input logic [31:0] pc,
                             input logic [4:0] a3, input logic wr, input logic [1:0] tn);
    check({"instr_", s}, ins, e.instr);
    check({"pc_", s}, pc, e.pc);
    check({"A3_", s}, 32'(a3), 32'(e.a3));
    check({"RegWr_", s}, 32'(wr), 32'(e.wr));
    check({"Tnew_", s}, 32'(tn), 32'(e.tn));
  endtask

  // One clock: drive D-side inputs, predict, clock, compare all three stages.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                      input logic st, input logic fl, input logic rst);
    rec_t e_new;
    instr_D = ins;
    pc_D    = pc;
    stall   = st;
    flush_E = fl;
    reset   = rst;
    if (rst)           e_new = empty_rec();
    else if (st || fl) e_new = empty_rec();
    else               e_new = ref_dec(ins, pc);
    exp_q.push_back(e_new);
    m_w = rst ? empty_rec() : age(m_m);
    m_m = rst ? empty_rec() : age(m_e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      m_e = exp_q.pop_front();
    end
    check_stage("E", m_e, instr_E, pc_E, A3_E, RegWr_E, Tnew_E);
    check_stage("M", m_m, instr_M, pc_M, A3_M, RegWr_M, Tnew_M);
    check_stage("W", m_w, instr_W, pc_W, A3_W, RegWr_W, Tnew_W);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush_E = 1'b0; instr_D = I_JUNK; pc_D = 32'hFFFF_FFFC;
    m_e = empty_rec(); m_m = empty_rec(); m_w = empty_rec();
    @(negedge clk);

    // Reset with garbage on D, stall and flush also high on the second cycle.
    step(I_JUNK, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    step(I_JUNK, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
    check("reset_pc_W", pc_W, PCR);

    // lw $8 travels E -> M -> W with Tnew 2, 1, 0.
    step(I_LW8, 32'h3000, 1'b0, 1'b0, 1'b0);
    check("lw_Tnew_E", 32'(Tnew_E), 32'd2);
    check("lw_A3_E", 32'(A3_E), 32'd8);
    step(I_NOP, 32'h3004, 1'b0, 1'b0, 1'b0);
    check("lw_Tnew_M", 32'(Tnew_M), 32'd1);
    step(I_ADDU, 32'h3008, 1'b1, 1'b0, 1'b0);
    check("lw_Tnew_W", 32'(Tnew_W), 32'd0);
    check("lw_A3_W", 32'(A3_W), 32'd8);
    check("stall_bubble_RegWr_E", 32'(RegWr_E), 32'd0);

    // addu released after its one stalled cycle.
    step(I_ADDU, 32'h3008, 1'b0, 1'b0, 1'b0);
    check("addu_A3_E", 32'(A3_E), 32'd3);
    check("addu_Tnew_E", 32'(Tnew_E), 32'd1);

    // jal writes $31 with Tnew 0, staying 0 downstream.
    step(I_JAL, 32'h300C, 1'b0, 1'b0, 1'b0);
    check("jal_A3_E", 32'(A3_E), 32'd31);
    step(I_NOP, 32'h3010, 1'b0, 1'b0, 1'b0);
    check("jal_Tnew_M", 32'(Tnew_M), 32'd0);

    // Writes to $0 and stores never assert RegWr.
    step(I_ORI0, 32'h3014, 1'b0, 1'b0, 1'b0);
    check("ori0_RegWr_E", 32'(RegWr_E), 32'd0);
    step(I_SW, 32'h3018, 1'b0, 1'b0, 1'b0);
    check("sw_A3_E", 32'(A3_E), 32'd0);

    // flush_E alone bubbles E.
    step(I_ADDU, 32'h301C, 1'b0, 1'b1, 1'b0);

    // lw into M, then reset with stall and flush high mid-stream.
    step(I_LW8, 32'h3020, 1'b0, 1'b0, 1'b0);
    step(I_NOP, 32'h3024, 1'b0, 1'b0, 1'b0);
    check("lw_in_M_A3_M", 32'(A3_M), 32'd8);
    step(I_ADDU, 32'h3028, 1'b1, 1'b1, 1'b1);
    check("midreset_A3_M", 32'(A3_M), 32'd0);
    step(I_ADDU, 32'h3028, 1'b1, 1'b1, 1'b0);
    step(I_ADDU, 32'h3028, 1'b0, 1'b0, 1'b0);
    check("post_reset_addu_A3_E", 32'(A3_E), 32'd3);
    step(I_NOP, 32'h302C, 1'b0, 1'b0, 1'b0);
    check("single_bubble_A3_W", 32'(A3_W), 32'd0);
    step(I_NOP, 32'h3030, 1'b0, 1'b0, 1'b0);
    check("addu_reaches_W", 32'(A3_W), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
